// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One product/quotient bit per cycle behind a start/busy/done handshake.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 is_div_q, is_div_d;
  logic                 res_neg_q, res_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 dbz_q, dbz_d;
  logic                 done_q, done_d;
  logic                 dbz_out_q, dbz_out_d;

  // Operand preparation for an accepted request
  logic             op_signed, op_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_signed = (op_i == OpMult) || (op_i == OpDiv);
  assign op_div    = (op_i == OpDiv) || (op_i == OpDivu);
  assign a_neg     = op_signed & a_i[WIDTH-1];
  assign b_neg     = op_signed & b_i[WIDTH-1];
  assign a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
  assign b_mag     = b_neg ? (~b_i + 1'b1) : b_i;

  // Multiply step: acc = {partial product, remaining multiplier bits}
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: acc = {remainder, dividend bits shifting into quotient}
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_qbit;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_qbit  = ~div_diff[WIDTH];
  assign div_rem   = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_qbit};

  logic [2*WIDTH-1:0] iter_next, prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  assign iter_next = is_div_q ? div_next : mul_next;
  assign prod_fix  = res_neg_q ? (~iter_next + 1'b1) : iter_next;
  assign quo       = iter_next[WIDTH-1:0];
  assign rem       = iter_next[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          case (op_i)
            OpMult, OpMultu, OpDiv, OpDivu: begin
              acc_d     = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
              opnd_d    = op_div ? b_mag : a_mag;
              a_raw_d   = a_i;
              is_div_d  = op_div;
              res_neg_d = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              dbz_d     = op_div && (b_i == '0);
              cnt_d     = CntW'(WIDTH);
              state_d   = StRun;
            end
            OpMthi:  hi_d = a_i;
            OpMtlo:  lo_d = a_i;
            default: ;
          endcase
        end
      end
      StRun: begin
        acc_d = iter_next;
        cnt_d = cnt_q - 1'b1;
        // Last iteration: commit the sign-corrected result on this same edge
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (dbz_q) begin
            hi_d      = a_raw_q;
            lo_d      = '1;
            dbz_out_d = 1'b1;
          end else begin
            hi_d = rem_neg_q ? (~rem + 1'b1) : rem;
            lo_d = res_neg_q ? (~quo + 1'b1) : quo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign busy_o        = (state_q == StRun);
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_out_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule
